// File: rtl/exec_muldiv.sv
// exec_muldiv: iterative RV32M multiply/divide unit for the EX stage.
//
// state  | meaning
// S_IDLE | waiting for an M-op; divide-by-zero / signed overflow resolved here
// S_BUSY | one shift-add or restoring-divide step per cycle, XLEN cycles
// S_DONE | result valid, done pulsed, pipeline released
//
// The result register is loaded on the edge that enters S_DONE, so it is
// already valid during the done cycle and then holds until the next completion.
module exec_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start_E,
  input  logic [2:0]      op_E,
  input  logic [XLEN-1:0] rs1_data_E,
  input  logic [XLEN-1:0] rs2_data_E,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy,
  output logic            stall_req
);

  localparam int CNT_W = $clog2(XLEN);
  localparam int ACC_W = 2*XLEN + 1;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]       op_q;
  logic [XLEN-1:0]  a_mag_q;
  logic [XLEN-1:0]  b_mag_q;
  logic [XLEN-1:0]  sh_q;      // multiplier (shifts right) or dividend (shifts left)
  logic [ACC_W-1:0] acc_q;     // mul: {carry, product}; div: {0, remainder, quotient}
  logic             neg_res_q;
  logic [CNT_W-1:0] count_q;

  logic            a_signed_in, b_signed_in;
  logic            a_neg_in, b_neg_in, neg_in;
  logic            div_zero_in, div_ovf_in, fast_in;
  logic            accept;
  logic [XLEN-1:0] a_abs_in, b_abs_in, fast_val;

  logic [XLEN-1:0]  mul_add;
  logic [XLEN:0]    mul_sum;
  logic [XLEN:0]    div_part;
  logic             div_ge;
  logic [XLEN-1:0]  div_rem;
  logic [ACC_W-1:0] acc_step;
  logic [XLEN-1:0]  sh_step;

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_val;

  // Decode incoming op: operand signedness, magnitudes, result sign, fast path.
  always_comb begin
    a_signed_in = (op_E == OP_MUL) | (op_E == OP_MULH) | (op_E == OP_MULHSU) |
                  (op_E == OP_DIV) | (op_E == OP_REM);
    b_signed_in = (op_E == OP_MUL) | (op_E == OP_MULH) |
                  (op_E == OP_DIV) | (op_E == OP_REM);
    a_neg_in    = a_signed_in & rs1_data_E[XLEN-1];
    b_neg_in    = b_signed_in & rs2_data_E[XLEN-1];
    a_abs_in    = a_neg_in ? -rs1_data_E : rs1_data_E;
    b_abs_in    = b_neg_in ? -rs2_data_E : rs2_data_E;
    // Remainders take the dividend's sign; everything else is the XOR.
    // Unsigned ops have both neg flags clear, so they come out positive.
    neg_in      = (op_E[2] & op_E[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);
    div_zero_in = (rs2_data_E == '0);
    div_ovf_in  = ~op_E[0] & (rs1_data_E == {1'b1, {(XLEN-1){1'b0}}}) &
                  (rs2_data_E == '1);
    fast_in     = op_E[2] & (div_zero_in | div_ovf_in);
    if (div_zero_in) begin
      fast_val = op_E[1] ? rs1_data_E : '1;
    end else begin
      fast_val = op_E[1] ? '0 : rs1_data_E;
    end
    accept = (state_q == S_IDLE) & start_E & ~flush;
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_add  = sh_q[0] ? a_mag_q : {XLEN{1'b0}};
    mul_sum  = acc_q[ACC_W-1:XLEN] + {1'b0, mul_add};
    div_part = {acc_q[2*XLEN-1:XLEN], sh_q[XLEN-1]};
    div_ge   = (div_part >= {1'b0, b_mag_q});
    div_rem  = div_ge ? (div_part[XLEN-1:0] - b_mag_q) : div_part[XLEN-1:0];
    if (op_q[2]) begin
      acc_step = {1'b0, div_rem, acc_q[XLEN-2:0], div_ge};
      sh_step  = {sh_q[XLEN-2:0], 1'b0};
    end else begin
      acc_step = {1'b0, mul_sum, acc_q[XLEN-1:1]};
      sh_step  = {1'b0, sh_q[XLEN-1:1]};
    end
  end

  // Select and sign-correct the final value from the last iteration's output.
  // MULH* negates the whole double-width product before picking the top half.
  always_comb begin
    prod_s = neg_res_q ? -acc_step[2*XLEN-1:0] : acc_step[2*XLEN-1:0];
    quo_s  = neg_res_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_s  = neg_res_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       final_val = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_val = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_val = quo_s;
      default:                      final_val = rem_s;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; flush overrides every transition.
  always_comb begin
    state_d   = state_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    stall_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_req = start_E & ~flush;
        if (start_E) begin
          state_d = fast_in ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        stall_req = 1'b1;
        if (count_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
    end
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      sh_q      <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      count_q   <= '0;
      result    <= '0;
    end else if (accept) begin
      op_q      <= op_E;
      a_mag_q   <= a_abs_in;
      b_mag_q   <= b_abs_in;
      sh_q      <= op_E[2] ? a_abs_in : b_abs_in;
      acc_q     <= '0;
      neg_res_q <= neg_in;
      count_q   <= CNT_W'(XLEN-1);
      if (fast_in) begin
        result <= fast_val;
      end
    end else if ((state_q == S_BUSY) && !flush) begin
      acc_q   <= acc_step;
      sh_q    <= sh_step;
      count_q <= count_q - CNT_W'(1);
      if (count_q == '0) begin
        result <= final_val;
      end
    end
  end

endmodule
